// File: rtl/concatenar_pkg.sv
// concatenar_pkg: shared state type and sizing helpers for the symbol concatenator
package concatenar_pkg;
  typedef enum logic [1:0] {VAZIO, ENCHENDO, CHEIO} estado_t;
  function automatic int cw_calc(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction
  function automatic bit cfg_ok(input int width, input int digit);
    return digit > 0 && digit <= width && width % digit == 0;
  endfunction
endpackage

// File: rtl/concatenar_registrado_inicial.sv
// inicial_constante: drives the constant seed value loaded into the word register
module inicial_constante #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  output logic [WIDTH-1:0] valor_o
);
  assign valor_o = INIT;
endmodule

// File: rtl/concatenar_registrado.sv
// concatenar_registrado: assembles DIGIT-bit symbols into a seeded WIDTH-bit word with valid/ready on both sides
module concatenar_registrado
  import concatenar_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = cw_calc(WIDTH, DIGIT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [DIGIT-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  localparam int N = WIDTH / DIGIT;
  if (!cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("concatenar_registrado: WIDTH must be a nonzero multiple of DIGIT");
  end
  estado_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, init_val, shifted;
  logic [CW-1:0] count_q, count_d;
  logic accept, consume, last;
  inicial_constante #(.WIDTH(WIDTH), .INIT(INIT)) u_init (.valor_o(init_val));
  assign in_ready = state_q != CHEIO;
  assign out_valid = state_q == CHEIO;
  assign out_data = data_q;
  assign count = count_q;
  assign accept = in_valid && in_ready;
  assign consume = out_valid && out_ready;
  assign last = count_q == CW'(N - 1);
  // shift operators rather than slices so the single-symbol word (N = 1) needs no special case
  assign shifted = MSB_FIRST ? (data_q << DIGIT) | WIDTH'(in_data)
                             : (data_q >> DIGIT) | (WIDTH'(in_data) << (WIDTH - DIGIT));
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    count_d = count_q;
    if (clear || consume) begin
      state_d = VAZIO;
      data_d = init_val;
      count_d = '0;
    end else if (accept) begin
      state_d = last ? CHEIO : ENCHENDO;
      data_d = shifted;
      count_d = count_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= VAZIO;
      data_q <= init_val;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_concatenar_registrado.sv
// tb_concatenar_registrado: directed and random checks of four configurations against an arithmetic word model
module tb_concatenar_registrado;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, clear;
  logic [3:0] din, iv, ordy, rdy, ov;
  logic [7:0] a_do, b_do, d_do;
  logic [15:0] c_do;
  logic [3:0] a_cnt, b_cnt;
  logic [2:0] c_cnt;
  logic [1:0] d_cnt;
  concatenar_registrado #(.WIDTH(8), .DIGIT(1), .INIT(8'h00), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[0]), .in_data(din[0:0]), .in_ready(rdy[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(a_do), .count(a_cnt));
  concatenar_registrado #(.WIDTH(8), .DIGIT(1), .INIT(8'h00), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[1]), .in_data(din[0:0]), .in_ready(rdy[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(b_do), .count(b_cnt));
  concatenar_registrado #(.WIDTH(16), .DIGIT(4), .INIT(16'hFFFF), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[2]), .in_data(din), .in_ready(rdy[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(c_do), .count(c_cnt));
  concatenar_registrado #(.WIDTH(8), .DIGIT(4), .INIT(8'h00), .MSB_FIRST(1'b1)) u_d (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[3]), .in_data(din), .in_ready(rdy[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(d_do), .count(d_cnt));
  int W[4] = '{8, 8, 16, 8};
  int D[4] = '{1, 1, 4, 4};
  int unsigned INI[4] = '{0, 0, 'hFFFF, 0};
  bit MSB[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int unsigned m_data[4];
  int m_cnt[4];
  int nchk = 0, npass = 0;
  logic [7:0] bits;
  function automatic logic [31:0] dut_data(input int i);
    return i == 0 ? 32'(a_do) : i == 1 ? 32'(b_do) : i == 2 ? 32'(c_do) : 32'(d_do);
  endfunction
  function automatic logic [31:0] dut_cnt(input int i);
    return i == 0 ? 32'(a_cnt) : i == 1 ? 32'(b_cnt) : i == 2 ? 32'(c_cnt) : 32'(d_cnt);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int n = W[i] / D[i];
      int unsigned sym = 32'(din) % (2 ** D[i]);
      if (reset || clear || (m_cnt[i] == n && ordy[i])) begin
        m_data[i] = INI[i];
        m_cnt[i] = 0;
      end else if (m_cnt[i] < n && iv[i]) begin
        m_data[i] = MSB[i] ? (m_data[i] * (2 ** D[i]) + sym) % (2 ** W[i])
                           : m_data[i] / (2 ** D[i]) + sym * (2 ** (W[i] - D[i]));
        m_cnt[i]++;
      end
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      int n = W[i] / D[i];
      chk($sformatf("data%0d", i), dut_data(i), m_data[i]);
      chk($sformatf("count%0d", i), dut_cnt(i), 32'(m_cnt[i]));
      chk($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(m_cnt[i] == n));
      chk($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(m_cnt[i] != n));
    end
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic drive(input logic [3:0] v, input logic [3:0] r, input logic [3:0] d);
    iv = v;
    ordy = r;
    din = d;
  endtask
  initial begin
    reset = 1'b1;
    clear = 1'b0;
    drive(4'h0, 4'h0, 4'h0);
    step();
    reset = 1'b0;
    chk("rst_a_data", 32'(a_do), 32'h00);
    chk("rst_a_count", 32'(a_cnt), 0);
    chk("rst_a_out_valid", 32'(ov[0]), 0);
    chk("rst_a_in_ready", 32'(rdy[0]), 1);
    chk("rst_c_data", 32'(c_do), 32'hFFFF);
    bits = 8'b1011_0010;
    for (int k = 0; k < 8; k++) begin
      drive(4'b0011, 4'h0, {3'b000, bits[7-k]});
      step();
      if (k == 6) chk("a_out_valid_early", 32'(ov[0]), 0);
    end
    chk("a_word_msb", 32'(a_do), 32'hB2);
    chk("b_word_lsb", 32'(b_do), 32'h4D);
    chk("a_out_valid", 32'(ov[0]), 1);
    drive(4'h0, 4'b0011, 4'h0);
    step();
    chk("a_after_consume", 32'(a_do), 32'h00);
    for (int k = 0; k < 4; k++) begin
      drive(4'b0100, 4'h0, 4'(k + 1));
      step();
    end
    chk("c_word", 32'(c_do), 32'h1234);
    chk("c_count_full", 32'(c_cnt), 4);
    for (int k = 0; k < 5; k++) begin
      drive(4'h0, 4'h0, 4'h0);
      step();
      chk("c_hold_data", 32'(c_do), 32'h1234);
      chk("c_hold_in_ready", 32'(rdy[2]), 0);
    end
    drive(4'h0, 4'b0100, 4'h0);
    step();
    chk("c_consume_data", 32'(c_do), 32'hFFFF);
    chk("c_consume_count", 32'(c_cnt), 0);
    drive(4'b1000, 4'h0, 4'h5);
    step();
    drive(4'b1000, 4'h0, 4'h6);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(4'b1000, 4'h0, 4'hA);
      step();
      chk("d_backpressure_count", 32'(d_cnt), 2);
      chk("d_backpressure_data", 32'(d_do), 32'h56);
    end
    drive(4'h0, 4'b1000, 4'h0);
    step();
    chk("d_consume_data", 32'(d_do), 32'h00);
    drive(4'b0100, 4'h0, 4'h5);
    step();
    drive(4'b0100, 4'h0, 4'h6);
    step();
    clear = 1'b1;
    drive(4'b0100, 4'h0, 4'h7);
    step();
    clear = 1'b0;
    chk("clear_data", 32'(c_do), 32'hFFFF);
    chk("clear_count", 32'(c_cnt), 0);
    drive(4'b0100, 4'h0, 4'h8);
    step();
    chk("clear_no_dropped_nibble", 32'(c_do), 32'hFFF8);
    drive(4'b0100, 4'h0, 4'h1);
    step();
    drive(4'b0100, 4'h0, 4'h2);
    step();
    chk("midword_count", 32'(c_cnt), 3);
    reset = 1'b1;
    drive(4'b0100, 4'h0, 4'h3);
    step();
    reset = 1'b0;
    chk("midreset_data", 32'(c_do), 32'hFFFF);
    chk("midreset_count", 32'(c_cnt), 0);
    for (int k = 0; k < 4; k++) begin
      drive(4'b0100, 4'h0, 4'(9 + k));
      step();
    end
    chk("after_reset_word", 32'(c_do), 32'h9ABC);
    drive(4'h0, 4'b1111, 4'h0);
    step();
    for (int k = 0; k < 400; k++) begin
      clear = $urandom_range(0, 19) == 0;
      reset = $urandom_range(0, 49) == 0;
      drive(4'($urandom), 4'($urandom), 4'($urandom));
      step();
    end
    reset = 1'b0;
    clear = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/concatenar_registrado.md
# concatenar_registrado

Parametrised, registered successor to the team's constant-zero initial-value generator. It holds a WIDTH-bit word that starts at a programmable constant (INIT, zero by default) and concatenates incoming DIGIT-bit symbols into it one per handshake. When the word is complete it is presented on a valid/ready output, and on consumption the register returns to INIT. It sits between symbol producers (keypad/serial decoders) and the arithmetic datapath, which needs a seeded accumulator.

## Interface
Parameters:
- WIDTH, 8, width of the assembled word; must be a multiple of DIGIT.
- DIGIT, 1, bits per incoming symbol.
- INIT, 0, WIDTH-bit value loaded on reset, on clear and after consumption.
- MSB_FIRST, 1: 1 shifts left with the new symbol into the LSBs; 0 shifts right with the new symbol into the MSBs.

Ports:
- clk, in, 1, the single clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-high; one cycle is sufficient.
- clear, in, 1, synchronous abort of the current word.
- in_valid, in, 1, a symbol is offered.
- in_data, in, DIGIT, symbol value.
- in_ready, out, 1, block accepts a symbol this cycle.
- out_valid, out, 1, word is complete.
- out_ready, in, 1, consumer takes the word.
- out_data, out, WIDTH, current register contents, always visible.
- count, out, CW = $clog2(WIDTH/DIGIT+1), number of symbols accepted.

## Operation
- N = WIDTH/DIGIT symbols per word.
- States:
  - VAZIO: count = 0.
  - ENCHENDO: 0 < count < N.
  - CHEIO: count = N.
- Accept means in_valid & in_ready.
- in_ready = 1 in VAZIO and ENCHENDO, 0 in CHEIO. out_valid = 1 only in CHEIO.
- On accept with MSB_FIRST = 1: data <= {data[WIDTH-DIGIT-1:0], in_data}.
- On accept with MSB_FIRST = 0: data <= {in_data, data[WIDTH-1:DIGIT]}.
- count increments by 1 on each accept. The accept that makes count = N moves the state to CHEIO.
- In CHEIO with out_ready = 1: data <= INIT, count <= 0, state to VAZIO.
- While in CHEIO without out_ready, data and count hold.
- Priority, highest first: reset, clear, consume, accept.
- clear in any state loads INIT and sets count to 0 and the state to VAZIO. A symbol offered in the same cycle is dropped and not counted.
- Accept and consume never coincide because in_ready = 0 in CHEIO.
- A new symbol can be accepted on the cycle after consumption.
- Case N = 1: the first accept goes straight from VAZIO to CHEIO.
- Reset values: data = INIT, count = 0, in_ready = 1, out_valid = 0.
- Reset asserted mid-word gives the same result as clear.
- in_data is ignored whenever no accept occurs.

## Timing
- All outputs are registered or decoded from the state only. There is no combinational path from in_valid, in_data or out_ready to any output.
- Latency: out_data reflects an accepted symbol one cycle after the accepting edge.
- out_valid rises on the cycle after the N-th accept.
- The minimum word period is N+1 cycles: N accepts plus 1 consume cycle.
- The consumer may hold out_ready low indefinitely. The word and out_valid stay stable until it is consumed.
- The producer must hold in_data stable while in_valid = 1 and in_ready = 0.

## Structure
- Shared package (concatenar_pkg):
  - the state enum (VAZIO, ENCHENDO, CHEIO);
  - a function computing CW from WIDTH and DIGIT;
  - elaboration-time checks for WIDTH % DIGIT == 0 and DIGIT ≤ WIDTH.
- One sub-module, inicial_constante. It is the parametrised form of the constant generator: it drives a WIDTH-bit value equal to INIT and is instantiated as the register's load source.
- The shift and count logic stays in the top module.

## Test plan
- Default parameters (WIDTH = 8, DIGIT = 1, INIT = 0):
  - Reset: out_data = 0x00, count = 0, out_valid = 0, in_ready = 1.
  - Feed bits 1,0,1,1,0,0,1,0: out_valid rises the cycle after the 8th accept with out_data = 0xB2.
- MSB_FIRST = 0 with the same bits: out_data = 0x4D.
- WIDTH = 16, DIGIT = 4, INIT = 0xFFFF:
  - Feed nibbles 0x1, 0x2, 0x3, 0x4: out_data = 0x1234.
  - Hold out_ready = 0 for 5 cycles: out_data stays 0x1234 and in_ready stays 0.
  - Pulse out_ready: the next cycle shows out_data = 0xFFFF and count = 0.
- Back-pressure with WIDTH = 8, DIGIT = 4: present in_valid = 1 with in_data = 0xA continuously while in CHEIO. Required: no accept and count stays 2.
- clear after 2 of 4 nibbles (WIDTH = 16), with in_valid = 1 in the same cycle: the next cycle shows out_data = INIT and count = 0. The dropped nibble must not appear.
- Reset asserted mid-word (count = 3): same result as clear. A following full word assembles correctly.
